// File: rtl/riscv_pipeline_pkg.sv
// rtl/riscv_pipeline_pkg.sv - shared pipeline-control types and constants
// Holds the hazard FSM state encoding, the x0 register index, the control
// bundle driven into PC / IF/ID / ID/EX, and the load-use detect function.
package riscv_pipeline_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FREEZE     = 2'd2
    } hz_state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic pc_sel;
    } hz_ctrl_t;

    // NOP bundle: both pipeline registers are loaded with a NOP, nothing advances.
    localparam hz_ctrl_t CTRL_NOP    = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
                                         idex_bubble: 1'b1, pc_sel: 1'b0};
    localparam hz_ctrl_t CTRL_RUN    = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                         idex_bubble: 1'b0, pc_sel: 1'b0};
    localparam hz_ctrl_t CTRL_HOLD   = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                         idex_bubble: 1'b0, pc_sel: 1'b0};
    localparam hz_ctrl_t CTRL_STALL  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                         idex_bubble: 1'b1, pc_sel: 1'b0};
    localparam hz_ctrl_t CTRL_BRANCH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                         idex_bubble: 1'b1, pc_sel: 1'b1};

    function automatic logic load_use_hazard(
        input logic       idex_memread,
        input logic [4:0] idex_rd,
        input logic [4:0] ifid_rs1,
        input logic [4:0] ifid_rs2,
        input logic       ifid_uses_rs2
    );
        return idex_memread && (idex_rd != REG_X0) &&
               ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
// Ports: clk, rst_n (async active-low), clr_i (sync clear, wins over en_i),
// en_i (count enable), cnt_o (current count, holds at all-ones).
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - load-use / branch / memory-freeze hazard controller
// Inputs: clock, reset (async active-low), IFID_Rs1/Rs2/Uses_Rs2 (decode operands),
// IDEX_MemRead/IDEX_Rd (instruction in EX), EX_Branch_Taken, Mem_Busy.
// Outputs: PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, PC_Sel (Mealy controls),
// Stall_Count, Flush_Count (saturating statistics), Mem_Timeout (sticky watchdog).
module hazard_control_unit
    import riscv_pipeline_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       IFID_Rs1,
    input  logic [4:0]       IFID_Rs2,
    input  logic             IFID_Uses_Rs2,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_Rd,
    input  logic             EX_Branch_Taken,
    input  logic             Mem_Busy,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Bubble,
    output logic             PC_Sel,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count,
    output logic             Mem_Timeout
);

    // Wide enough to reach TIMEOUT_CYCLES before saturating.
    localparam int FRZ_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FRZ_W-1:0] FRZ_LAST = FRZ_W'(TIMEOUT_CYCLES - 1);

    hz_state_e        state_q, state_d;
    hz_ctrl_t         ctrl;
    logic             hazard;
    logic             branch_fire;
    logic             timeout_q;
    logic [FRZ_W-1:0] frz_cnt;

    assign hazard = load_use_hazard(IDEX_MemRead, IDEX_Rd, IFID_Rs1, IFID_Rs2, IFID_Uses_Rs2);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        ctrl        = CTRL_RUN;
        state_d     = RUN;
        branch_fire = 1'b0;
        if (!reset) begin
            ctrl = CTRL_NOP;
        end else if (Mem_Busy) begin
            ctrl    = CTRL_HOLD;
            state_d = FREEZE;
        end else if (EX_Branch_Taken) begin
            ctrl        = CTRL_BRANCH;
            branch_fire = 1'b1;
        end else if (hazard && (state_q != LOAD_STALL)) begin
            // ID/EX already holds the bubble in LOAD_STALL, so a second stall
            // would be spurious. Leaving FREEZE evaluates like RUN.
            ctrl    = CTRL_STALL;
            state_d = LOAD_STALL;
        end
    end

    assign PC_Write    = ctrl.pc_write;
    assign IFID_Write  = ctrl.ifid_write;
    assign IFID_Flush  = ctrl.ifid_flush;
    assign IDEX_Bubble = ctrl.idex_bubble;
    assign PC_Sel      = ctrl.pc_sel;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clock),
        .rst_n (reset),
        .clr_i (1'b0),
        .en_i  (!ctrl.pc_write),
        .cnt_o (Stall_Count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clock),
        .rst_n (reset),
        .clr_i (1'b0),
        .en_i  (branch_fire),
        .cnt_o (Flush_Count)
    );

    sat_counter #(.W(FRZ_W)) u_freeze_cnt (
        .clk   (clock),
        .rst_n (reset),
        .clr_i (!Mem_Busy),
        .en_i  (Mem_Busy),
        .cnt_o (frz_cnt)
    );

    // Sets on the edge that takes the freeze count to TIMEOUT_CYCLES.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timeout_q <= 1'b0;
        end else if (Mem_Busy && (frz_cnt >= FRZ_LAST)) begin
            timeout_q <= 1'b1;
        end
    end

    assign Mem_Timeout = timeout_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - directed self-checking bench for hazard_control_unit
module tb_hazard_control_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  IFID_Rs1, IFID_Rs2, IDEX_Rd;
    logic        IFID_Uses_Rs2, IDEX_MemRead, EX_Branch_Taken, Mem_Busy;
    logic        PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, PC_Sel;
    logic [31:0] Stall_Count, Flush_Count;
    logic        Mem_Timeout;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    // {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, PC_Sel}
    localparam logic [4:0] O_RUN    = 5'b11000;
    localparam logic [4:0] O_STALL  = 5'b00010;
    localparam logic [4:0] O_BRANCH = 5'b11111;
    localparam logic [4:0] O_FREEZE = 5'b00000;
    localparam logic [4:0] O_RESET  = 5'b00110;

    hazard_control_unit #(.TIMEOUT_CYCLES(8), .CNT_W(32)) dut (
        .clock           (clock),
        .reset           (reset),
        .IFID_Rs1        (IFID_Rs1),
        .IFID_Rs2        (IFID_Rs2),
        .IFID_Uses_Rs2   (IFID_Uses_Rs2),
        .IDEX_MemRead    (IDEX_MemRead),
        .IDEX_Rd         (IDEX_Rd),
        .EX_Branch_Taken (EX_Branch_Taken),
        .Mem_Busy        (Mem_Busy),
        .PC_Write        (PC_Write),
        .IFID_Write      (IFID_Write),
        .IFID_Flush      (IFID_Flush),
        .IDEX_Bubble     (IDEX_Bubble),
        .PC_Sel          (PC_Sel),
        .Stall_Count     (Stall_Count),
        .Flush_Count     (Flush_Count),
        .Mem_Timeout     (Mem_Timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {27'd0, PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, PC_Sel};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic rd_mem, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic uses2, input logic br,
                         input logic busy);
        IDEX_MemRead    = rd_mem;
        IDEX_Rd         = rd;
        IFID_Rs1        = rs1;
        IFID_Rs2        = rs2;
        IFID_Uses_Rs2   = uses2;
        EX_Branch_Taken = br;
        Mem_Busy        = busy;
        #1;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_stall"}, Stall_Count, exp_stall);
        check({tag, "_flush"}, Flush_Count, exp_flush);
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check("rst_outs", outs(), {27'd0, O_RESET});
        check_counts("rst");
        check("rst_timeout", {31'd0, Mem_Timeout}, 32'd0);
        tick();
        reset = 1'b1;
        #1;
        check("run_idle", outs(), {27'd0, O_RUN});

        // load x5 in EX, rs1 = x5: one stall cycle
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        check("lu_rs1", outs(), {27'd0, O_STALL});
        tick(); exp_stall++;
        check("lu_ldstall_outs", outs(), {27'd0, O_RUN});
        check_counts("lu_rs1");
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check("lu_back_run", outs(), {27'd0, O_RUN});
        check_counts("lu_after");

        // no hazard: rd = x0, or rs2 not used
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("lu_x0", outs(), {27'd0, O_RUN});
        drive(1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0);
        check("lu_rs2_unused", outs(), {27'd0, O_RUN});
        drive(1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0);
        check("no_memread", outs(), {27'd0, O_RUN});
        tick();
        check_counts("nohaz");
        drive(1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0);
        check("lu_rs2_used", outs(), {27'd0, O_STALL});
        tick(); exp_stall++;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_counts("lu_rs2");

        // branch overrides a simultaneous load-use hazard
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0);
        check("br_over_lu", outs(), {27'd0, O_BRANCH});
        tick(); exp_flush++;
        check_counts("br");
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        check("br_then_run_haz", outs(), {27'd0, O_STALL});
        tick(); exp_stall++;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

        // Mem_Busy 3 cycles during a load-use hazard, then one stall cycle
        drive(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("frz_outs", outs(), {27'd0, O_FREEZE});
            tick(); exp_stall++;
        end
        drive(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0);
        check("frz_exit_stall", outs(), {27'd0, O_STALL});
        tick(); exp_stall++;
        check("frz_ldstall_run", outs(), {27'd0, O_RUN});
        check_counts("frz");
        check("frz_no_timeout", {31'd0, Mem_Timeout}, 32'd0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

        // two more branches -> counters 7 / 3
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick(); tick(); exp_flush += 2;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("pre_rst_stall", Stall_Count, 32'd7);
        check("pre_rst_flush", Flush_Count, 32'd3);

        // reset asserted mid-FREEZE, checked before the next edge
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick(); exp_stall++;
        check_counts("in_frz");
        #2;
        reset = 1'b0;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        check("async_rst_outs", outs(), {27'd0, O_RESET});
        check_counts("async_rst");
        drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        #1;
        check("rel_run_haz", outs(), {27'd0, O_STALL});
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("rel_run_idle", outs(), {27'd0, O_RUN});

        // watchdog: Mem_Busy 10 cycles with TIMEOUT_CYCLES = 8
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            tick(); exp_stall++;
            check($sformatf("wd_timeout_%0d", i), {31'd0, Mem_Timeout}, (i >= 8) ? 32'd1 : 32'd0);
        end
        check_counts("wd");
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check("wd_sticky", {31'd0, Mem_Timeout}, 32'd1);
        check("wd_run", outs(), {27'd0, O_RUN});
        #2;
        reset = 1'b0;
        #1;
        check("wd_rst_clear", {31'd0, Mem_Timeout}, 32'd0);
        check("wd_rst_stall", Stall_Count, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard controller for the 5-stage 64-bit RISC-V core. It consumes what the ID/EX register presents to the execute stage (load flag, destination register, branch outcome) and drives the write-enable, flush and bubble controls back into the PC, IF/ID and ID/EX registers. It covers load-use stalls, taken-branch flushes and data-memory freezes. It also keeps stall/flush statistics and a sticky memory-timeout flag.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: consecutive frozen cycles before Mem_Timeout sets.
- CNT_W, 32: width of the statistics counters.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low (0 = reset).
- IFID_Rs1  in  5  rs1 field of the instruction in decode.
- IFID_Rs2  in  5  rs2 field of the instruction in decode.
- IFID_Uses_Rs2  in  1  decode instruction reads rs2 (R/S/B types).
- IDEX_MemRead  in  1  instruction in EX is a load.
- IDEX_Rd  in  5  destination register of the instruction in EX.
- EX_Branch_Taken  in  1  branch in EX resolved taken (IDEX_Branch & condition).
- Mem_Busy  in  1  data memory cannot complete this cycle.
- PC_Write  out  1  PC register enable.
- IFID_Write  out  1  IF/ID register enable.
- IFID_Flush  out  1  load NOP into IF/ID.
- IDEX_Bubble  out  1  zero all control fields entering ID/EX.
- PC_Sel  out  1  1 = take branch target.
- Stall_Count  out  CNT_W  cycles with PC_Write=0 (excluding reset).
- Flush_Count  out  CNT_W  taken-branch flushes.
- Mem_Timeout  out  1  sticky watchdog flag.

## Operation
- States: RUN, LOAD_STALL, FREEZE. Registered state; outputs are Mealy (state + current inputs).
- Per-cycle priority: Mem_Busy > EX_Branch_Taken > load-use hazard.
- Load-use hazard: IDEX_MemRead & IDEX_Rd≠0 & (IDEX_Rd==IFID_Rs1 | (IFID_Uses_Rs2 & IDEX_Rd==IFID_Rs2)).
- RUN, no event: PC_Write=IFID_Write=1, IFID_Flush=IDEX_Bubble=PC_Sel=0.
- RUN, hazard: PC_Write=IFID_Write=0, IDEX_Bubble=1; next state LOAD_STALL.
- LOAD_STALL: lasts exactly one cycle. Outputs are as in RUN/no-event, and hazard detection is suppressed because ID/EX holds a bubble. Next state RUN, unless Mem_Busy or a branch applies.
- Branch taken (RUN or LOAD_STALL): PC_Sel=1, PC_Write=1, IFID_Flush=1, IDEX_Bubble=1. Flush_Count+1. Next state RUN. Branch overrides a simultaneous load-use.
- Mem_Busy=1 in any state: all enables 0, Flush/Bubble/PC_Sel 0, so the whole pipeline holds. Next state FREEZE.
- FREEZE, Mem_Busy=1: stay.
- FREEZE, Mem_Busy=0: return to RUN and evaluate the RUN rules that same cycle, on the un-disturbed ID/EX contents.
- Stall_Count increments on every cycle with PC_Write=0. Both counters saturate at all-ones and do not wrap.
- Freeze counter: counts consecutive Mem_Busy cycles, clears when Mem_Busy=0, saturates. When it reaches TIMEOUT_CYCLES, Mem_Timeout sets and stays set until reset.

## Timing
- Hazard and branch responses are combinational in the same cycle as the triggering inputs. Zero added latency.
- Load-use penalty: exactly 1 cycle. Taken-branch penalty: 2 flushed instructions (IF/ID and ID/EX), in a single cycle.
- Reset (reset=0, asynchronous):
  - State = RUN; Stall_Count = Flush_Count = 0; freeze counter = 0; Mem_Timeout = 0.
  - Combinational outputs while in reset: PC_Write=0, IFID_Write=0, IFID_Flush=1, IDEX_Bubble=1, PC_Sel=0.
- Reset release: the first clock edge with reset=1 operates in RUN.
- Reset asserted mid-FREEZE or mid-LOAD_STALL drops immediately to the reset values, with no pending stall retained.
- Mem_Timeout rises on the edge that makes the freeze count equal TIMEOUT_CYCLES.

## Structure
- Shared package riscv_pipeline_pkg holds:
  - the state encoding (RUN=2'd0, LOAD_STALL=2'd1, FREEZE=2'd2);
  - REG_X0 = 5'd0;
  - the NOP control bundle constant reused by IF/ID and ID/EX.
- One sub-module, sat_counter (parameterised width, enable, synchronous clear, saturate). It is instantiated three times: stall, flush and freeze counters.

## Test plan
- Load x5 in EX (IDEX_Rd=5, MemRead=1), IFID_Rs1=5 → one cycle PC_Write=0, IDEX_Bubble=1, then RUN with outputs normal; Stall_Count=1.
- Same with IDEX_Rd=0, or with IFID_Rs2=5 and IFID_Uses_Rs2=0 → no stall, Stall_Count=0.
- EX_Branch_Taken=1 together with a load-use hazard → PC_Sel=1, IFID_Flush=1, IDEX_Bubble=1, PC_Write=1; Flush_Count=1, Stall_Count=0.
- Mem_Busy held 3 cycles during a load-use hazard → 3 cycles of all-zero enables (FREEZE), then one load-use stall cycle; Stall_Count=4.
- TIMEOUT_CYCLES=8, Mem_Busy held 10 cycles → Mem_Timeout rises after the 8th cycle and remains 1 after Mem_Busy drops, until reset=0.
- Assert reset=0 mid-FREEZE with counters at 7/3 → counters read 0 and outputs show reset values asynchronously, before the next edge; Mem_Timeout cleared.
